uart_program_loader: RTL and testbench

- Boot-time controller between the UART receiver and the core's instruction memory write port.
- Parses a length header from the received byte stream and packs payload bytes into 32-bit little-endian words.
- Sequences the words into memory through a ready/valid write handshake, then sends an ack byte and releases the core with a one-cycle start pulse.
- After loading, it ignores further received bytes until reset.

---
 rtl/uart_program_loader.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_program_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// uart_program_loader
//   Boot-time loader between the UART receiver and the instruction memory
//   write port. A little-endian word count header is followed by payload
//   bytes that are packed into 32-bit little-endian words and written to
//   consecutive word addresses starting at BASE_ADDR. When the last word has
//   been written an ack byte is sent, and the core is released with a
//   one-cycle core_start pulse. After that, received bytes are ignored until
//   reset.
//
//   Optional feature, enabled by defining LOADER_CHECKSUM_EN:
//     an 8-bit running sum of all payload bytes is compared with one extra
//     byte received after the last word. A mismatch sends ACK_ERR and parks
//     the block in ERR without releasing the core.
//
//   Handshakes: a transfer on mem_* or tx_* happens on a rising clock edge
//   where valid && ready. The request side holds valid, address and data
//   stable until that edge and drops valid on the following cycle.
//   rx_valid is a one-cycle strobe with no back-pressure. A byte that is
//   not accepted is lost.
module uart_program_loader #(
    parameter int          ADDR_W    = 14,
    parameter int          HDR_BYTES = 1,
    parameter int unsigned BASE_ADDR = 0,
    parameter logic [7:0]  ACK_OK    = 8'hAA,
    parameter logic [7:0]  ACK_ERR   = 8'h55
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              core_start,
    output logic              done,
    output logic              overrun
);

    localparam int CNT_W  = HDR_BYTES * 8;
    localparam int HIDX_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_WORD  = 3'd1,
        S_WRITE = 3'd2,
        S_ACK   = 3'd3,
        S_DONE  = 3'd4,
        S_CSUM  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    // With the checksum enabled, the end of the payload waits for the sum byte.
    localparam state_t S_AFTER_LOAD = S_CSUM;
`else
    localparam state_t S_AFTER_LOAD = S_ACK;
`endif

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W-1:0]  word_idx;
    logic [HIDX_W-1:0] hdr_idx;
    logic [1:0]        byte_idx;
    logic              hdr_last;
    logic              last_word;
    logic              load_ok;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
    logic              csum_ok;
    assign load_ok = csum_ok;
`else
    // Without the checksum every completed load is a good one and ACK_ERR
    // never leaves the block.
    logic              unused_ack_err;
    assign unused_ack_err = ^ACK_ERR;
    assign load_ok        = 1'b1;
`endif

    assign hdr_last  = (hdr_idx == HIDX_W'(HDR_BYTES - 1));
    assign last_word = ((word_idx + CNT_W'(1)) == count);

    // Header count with the current byte merged in, so the zero-length
    // decision can be made on the same strobe that completes the header.
    always_comb begin
        cnt_next = count;
        cnt_next[8*hdr_idx +: 8] = rx_data;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_HDR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the handshake request outputs.
    always_comb begin
        state_next = state;
        mem_valid  = 1'b0;
        tx_valid   = 1'b0;
        case (state)
            S_HDR: begin
                if (rx_valid && hdr_last) begin
                    state_next = (cnt_next == '0) ? S_AFTER_LOAD : S_WORD;
                end
            end
            S_WORD: begin
                if (rx_valid && (byte_idx == 2'd3)) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_valid = 1'b1;
                if (mem_ready) begin
                    state_next = last_word ? S_AFTER_LOAD : S_WORD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (rx_valid) begin
                    state_next = S_ACK;
                end
            end
`endif
            S_ACK: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_next = load_ok ? S_DONE : S_ERR;
                end
            end
            default: begin
                state_next = state;
            end
        endcase
    end

    // Header byte collection, LSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            hdr_idx <= '0;
        end else if (state == S_HDR && rx_valid) begin
            count   <= cnt_next;
            hdr_idx <= hdr_idx + HIDX_W'(1);
        end
    end

    // Payload packing into little-endian byte lanes of the write data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wdata <= '0;
            byte_idx  <= '0;
        end else if (state == S_WORD && rx_valid) begin
            mem_wdata[8*byte_idx +: 8] <= rx_data;
            byte_idx                   <= byte_idx + 2'd1;
        end
    end

    // Word index and write address advance on each accepted write; the
    // address wraps silently at the top of the word space.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_idx <= '0;
            mem_addr <= ADDR_W'(BASE_ADDR);
        end else if (state == S_WRITE && mem_ready) begin
            word_idx <= word_idx + CNT_W'(1);
            mem_addr <= mem_addr + ADDR_W'(1);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running payload sum and the verdict taken from the trailing sum byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum    <= '0;
            csum_ok <= 1'b0;
        end else if (state == S_WORD && rx_valid) begin
            csum <= csum + rx_data;
        end else if (state == S_CSUM && rx_valid) begin
            csum_ok <= (rx_data == csum);
        end
    end
`endif

    // Ack byte selection, loaded when the ACK state is about to be entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data <= '0;
        end else if (state != S_ACK && state_next == S_ACK) begin
`ifdef LOADER_CHECKSUM_EN
            tx_data <= (rx_data == csum) ? ACK_OK : ACK_ERR;
`else
            tx_data <= ACK_OK;
`endif
        end
    end

    // Status flags: busy window, sticky done/overrun, and the start pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            core_start <= 1'b0;
        end else begin
            core_start <= 1'b0;
            if (state == S_HDR && rx_valid) begin
                busy <= 1'b1;
            end
            // Bytes arriving while a write is pending are dropped, including
            // one that coincides with the accepting edge.
            if (state == S_WRITE && rx_valid) begin
                overrun <= 1'b1;
            end
            if (state == S_ACK && tx_ready) begin
                busy <= 1'b0;
                if (load_ok) begin
                    done       <= 1'b1;
                    core_start <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Testbench for uart_program_loader: randomized byte streams against a
// byte-list reference model, with a queue scoreboard for memory writes and
// ack bytes.
`timescale 1ns/1ps
module tb_uart_program_loader;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              mem_valid;
  logic              mem_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic [7:0]        tx_data;
  logic              busy;
  logic              core_start;
  logic              done;
  logic              overrun;

  int tests = 0;
  int failures = 0;
  int start_cnt = 0;

  logic [ADDR_W+31:0] exp_mem_q[$];
  logic [7:0]         exp_tx_q[$];
  logic [7:0]         fix_q[$];

  logic               stall_hold = 1'b0;
  logic [ADDR_W-1:0]  hold_addr;
  logic [31:0]        hold_data;
  logic [ADDR_W+31:0] mon_e;
  logic [7:0]         mon_t;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  uart_program_loader dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .busy       (busy),
    .core_start (core_start),
    .done       (done),
    .overrun    (overrun)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    rx_valid  = 1'b0;
    mem_ready = 1'b0;
    tx_ready  = 1'b0;
    #1;
    chk("reset_outputs", {mem_valid, tx_valid, busy, core_start, done, overrun, tx_data, mem_wdata}, 64'd0);
    chk("reset_addr", 64'(mem_addr), 64'd0);
    exp_mem_q.delete();
    exp_tx_q.delete();
    idle(3);
    rst       = 1'b0;
    start_cnt = 0;
  endtask

  // One complete load. Model: payload bytes are grouped four at a time into
  // little-endian words written to addresses 0,1,2...; bytes injected while a
  // write is pending are not payload and only set the expected overrun.
  task automatic run_load(input int cnt, input bit ready_rand, input int stall_word,
                          input int stall_len, input int ovr_word, input int ovr_kind,
                          input bit bad_csum, input int abort_at);
    logic [7:0]  b;
    logic [31:0] word;
    logic [7:0]  sum;
    logic [7:0]  ack;
    bit          ok;
    bit          exp_ovr;
    int          sent;
    int          n_low;
    int          t;
    sum     = 8'h00;
    exp_ovr = 1'b0;
    sent    = 0;
    send_byte(8'(cnt));
    chk("busy_after_hdr", 64'(busy), 64'd1);
    for (int w = 0; w < cnt; w++) begin
      word = 32'h0;
      for (int k = 0; k < 4; k++) begin
        idle($urandom_range(0, 2));
        if (fix_q.size() > 0) b = fix_q.pop_front();
        else b = 8'($urandom);
        word[8*k +: 8] = b;
        sum = sum + b;
        send_byte(b);
        sent++;
        if (sent == abort_at) begin
          apply_reset();
          return;
        end
      end
      exp_mem_q.push_back({ADDR_W'(w), word});
      chk("mem_valid_latency", 64'(mem_valid), 64'd1);
      if (w == stall_word) n_low = stall_len;
      else n_low = ready_rand ? $urandom_range(0, 3) : 0;
      if (w == ovr_word && ovr_kind == 0 && n_low < 2) n_low = 2;
      for (int i = 0; i < n_low; i++) begin
        if (w == ovr_word && ovr_kind == 0 && i == 1) begin
          rx_data  = 8'($urandom);
          rx_valid = 1'b1;
          exp_ovr  = 1'b1;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
      end
      mem_ready = 1'b1;
      if (w == ovr_word && ovr_kind == 1) begin
        rx_data  = 8'($urandom);
        rx_valid = 1'b1;
        exp_ovr  = 1'b1;
      end
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      rx_valid  = 1'b0;
      chk("mem_valid_drop", 64'(mem_valid), 64'd0);
`ifndef LOADER_CHECKSUM_EN
      if (w == cnt - 1) chk("tx_valid_latency", 64'(tx_valid), 64'd1);
`endif
    end
`ifdef LOADER_CHECKSUM_EN
    idle($urandom_range(0, 2));
    ok = !bad_csum;
    send_byte(bad_csum ? sum + 8'd1 : sum);
`else
    ok = 1'b1;
`endif
    ack = ok ? 8'hAA : 8'h55;
    exp_tx_q.push_back(ack);
    t = 0;
    while (!tx_valid && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("tx_valid_wait", 64'(tx_valid), 64'd1);
    if (!tx_valid) return;
    idle($urandom_range(0, 3));
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    chk("core_start_pulse", 64'(core_start), 64'(ok));
    chk("busy_after_ack", 64'(busy), 64'd0);
    idle(2);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    idle(3);
    chk("done_flag", 64'(done), 64'(ok));
    chk("overrun_flag", 64'(overrun), 64'(exp_ovr));
    chk("start_count", 64'(start_cnt), ok ? 64'd1 : 64'd0);
    chk("mem_q_empty", 64'(exp_mem_q.size()), 64'd0);
    chk("tx_q_empty", 64'(exp_tx_q.size()), 64'd0);
  endtask

  task automatic push_pattern(input int words);
    for (int w = 0; w < words; w++)
      for (int k = 1; k <= 4; k++) fix_q.push_back(8'(k));
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      stall_hold = 1'b0;
    end else begin
      if (mem_valid && tx_valid) begin
        failures++;
        $display("FAIL excl: mem_valid=%0b tx_valid=%0b both high (t=%0t)", mem_valid, tx_valid, $time);
      end
      if (stall_hold && mem_valid) begin
        chk("stall_addr", 64'(mem_addr), 64'(hold_addr));
        chk("stall_data", 64'(mem_wdata), 64'(hold_data));
      end
      stall_hold = mem_valid && !mem_ready;
      hold_addr  = mem_addr;
      hold_data  = mem_wdata;
      if (mem_valid && mem_ready) begin
        if (exp_mem_q.size() == 0) begin
          failures++;
          $display("FAIL mem_unexpected: addr %0h data %0h expected no write", mem_addr, mem_wdata);
        end else begin
          mon_e = exp_mem_q.pop_front();
          chk("mem_addr", 64'(mem_addr), 64'(mon_e[ADDR_W+31:32]));
          chk("mem_wdata", 64'(mem_wdata), 64'(mon_e[31:0]));
        end
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx_q.size() == 0) begin
          failures++;
          $display("FAIL tx_unexpected: byte %0h expected no ack", tx_data);
        end else begin
          mon_t = exp_tx_q.pop_front();
          chk("tx_data", 64'(tx_data), 64'(mon_t));
        end
      end
      if (core_start) start_cnt++;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    apply_reset();

    // three words of 01 02 03 04, ready always high
    push_pattern(3);
    run_load(3, 1'b0, -1, 0, -1, 0, 1'b0, -1);

    // same stream, second write stalled for 20 cycles
    apply_reset();
    push_pattern(3);
    run_load(3, 1'b0, 1, 20, -1, 0, 1'b0, -1);

    // zero-length image
    apply_reset();
    run_load(0, 1'b0, -1, 0, -1, 0, 1'b0, -1);

    // byte strobed during a stalled write
    apply_reset();
    run_load(4, 1'b1, 1, 6, 1, 0, 1'b0, -1);

    // byte strobed on the accepting edge of a write
    apply_reset();
    run_load(3, 1'b1, -1, 0, 2, 1, 1'b0, -1);

    // reset after six payload bytes, then a fresh one-word load
    apply_reset();
    run_load(2, 1'b1, -1, 0, -1, 0, 1'b0, 6);
    fix_q.push_back(8'hAA);
    fix_q.push_back(8'hBB);
    fix_q.push_back(8'hCC);
    fix_q.push_back(8'hDD);
    run_load(1, 1'b0, -1, 0, -1, 0, 1'b0, -1);

`ifdef LOADER_CHECKSUM_EN
    apply_reset();
    push_pattern(1);
    run_load(1, 1'b0, -1, 0, -1, 0, 1'b0, -1);
    apply_reset();
    push_pattern(1);
    run_load(1, 1'b0, -1, 0, -1, 0, 1'b1, -1);
`endif

    // randomized loads
    for (int r = 0; r < 6; r++) begin
      int c;
      c = $urandom_range(1, 10);
      apply_reset();
      run_load(c, 1'b1, $urandom_range(0, c - 1), $urandom_range(0, 8),
               ($urandom_range(0, 1) == 1) ? $urandom_range(0, c - 1) : -1,
               $urandom_range(0, 1), ($urandom_range(0, 3) == 0), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
